// File: rtl/lu_acc_unit_if.sv
// Operand/result handshake bundle for lu_acc_unit.
// The operand source and the result consumer share the master side; the unit takes the slave side.
interface lu_acc_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, op, use_acc, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, op, use_acc, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/lu_acc_unit.sv
// Registered eight-way bitwise logic unit with a feedback accumulator and
// valid/ready handshakes on both the operand and the result side.
module lu_acc_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  lu_acc_unit_if.slave      bus,
  input  logic              acc_clear,
  output logic              zero,
  output logic [WIDTH-1:0]  acc,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [2:0] {
    OP_NOR  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_XNOR = 3'b011,
    OP_AND  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] func_out;

  // in_ready is forced high during reset so the source never sees a stale stall.
  assign bus.in_ready = reset || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign opnd_a       = bus.use_acc ? acc_q : bus.a;

  always_comb begin
    func_out = '0;
    case (op_e'(bus.op))
      OP_NOR:  func_out = ~(opnd_a | bus.b);
      OP_OR:   func_out =   opnd_a | bus.b;
      OP_XOR:  func_out =   opnd_a ^ bus.b;
      OP_XNOR: func_out = ~(opnd_a ^ bus.b);
      OP_AND:  func_out =   opnd_a & bus.b;
      OP_NAND: func_out = ~(opnd_a & bus.b);
      OP_NOTA: func_out =  ~opnd_a;
      OP_PASS: func_out =   bus.b;
      default: func_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      if (accept) begin
        result_q    <= func_out;
        out_valid_q <= 1'b1;
        count_q     <= count_q + CNT_W'(1);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A same-cycle accept still read the old acc as A'; clear only affects the stored value.
      if (acc_clear) begin
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= func_out;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign zero          = (result_q == '0);
  assign acc           = acc_q;
  assign count         = count_q;

endmodule
